// File: rtl/fetch_pc_unit_if.sv
// Fetch-side bus between the IF-stage PC unit and its neighbours (imem, predictor, ID, EX).
// BPU_PERF_EN adds the resolved-branch input and the two performance counters.
interface fetch_pc_unit_if #(
  parameter int ADDR_W = 32
);
  logic              stall;
  logic [31:0]       i_inst;
  logic [ADDR_W-1:0] o_pc;
  logic              o_B;
  logic              i_BrPre;
  logic              i_PreWrong;
  logic [ADDR_W-1:0] i_redirect_pc;
  logic              o_flush;
  logic [ADDR_W-1:0] o_pc_id;
  logic [31:0]       o_inst_id;
  logic              o_pred_id;
  logic              o_valid_id;
`ifdef BPU_PERF_EN
  logic              i_ex_is_br;
  logic [31:0]       o_br_cnt;
  logic [31:0]       o_miss_cnt;
`endif

  // Handshake: no valid/ready pair here. stall freezes the whole unit; i_PreWrong is
  // acted on only in an unstalled cycle, and EX keeps presenting it until then.
  modport slave (
    input  stall, i_inst, i_BrPre, i_PreWrong, i_redirect_pc,
`ifdef BPU_PERF_EN
    input  i_ex_is_br,
    output o_br_cnt, o_miss_cnt,
`endif
    output o_pc, o_B, o_flush, o_pc_id, o_inst_id, o_pred_id, o_valid_id
  );

  modport master (
    output stall, i_inst, i_BrPre, i_PreWrong, i_redirect_pc,
`ifdef BPU_PERF_EN
    output i_ex_is_br,
    input  o_br_cnt, o_miss_cnt,
`endif
    input  o_pc, o_B, o_flush, o_pc_id, o_inst_id, o_pred_id, o_valid_id
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// IF-stage PC generator with pre-decode, predicted-branch/JAL steering, EX redirect and IF/ID register.
// Optional BPU_PERF_EN adds saturating resolved-branch and misprediction counters.
module fetch_pc_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic             clk,
  input logic             rst_n,
  fetch_pc_unit_if.slave  bus
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]       inst;
  logic              is_br;
  logic              is_jal;
  logic [ADDR_W-1:0] imm_b;
  logic [ADDR_W-1:0] imm_j;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_id_q, pc_id_d;
  logic [31:0]       inst_id_q, inst_id_d;
  logic              pred_id_q, pred_id_d;
  logic              valid_id_q, valid_id_d;

  assign inst   = bus.i_inst;
  assign is_br  = (inst[6:0] == 7'b1100011);
  assign is_jal = (inst[6:0] == 7'b1101111);
  assign imm_b  = {{(ADDR_W-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j  = {{(ADDR_W-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    pc_d       = pc_q;
    pc_id_d    = pc_id_q;
    inst_id_d  = inst_id_q;
    pred_id_d  = pred_id_q;
    valid_id_d = valid_id_q;
    if (!bus.stall) begin
      if (bus.i_PreWrong) begin
        // The instruction now in IF came from the wrong path: drop it.
        pc_d       = bus.i_redirect_pc;
        inst_id_d  = NOP;
        pred_id_d  = 1'b0;
        valid_id_d = 1'b0;
      end else begin
        pc_id_d    = pc_q;
        inst_id_d  = inst;
        valid_id_d = 1'b1;
        if (is_br && bus.i_BrPre) begin
          pc_d      = pc_q + imm_b;
          pred_id_d = 1'b1;
        end else if (is_jal) begin
          pc_d      = pc_q + imm_j;
          pred_id_d = 1'b1;
        end else begin
          pc_d      = pc_q + ADDR_W'(4);
          pred_id_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      pc_id_q    <= '0;
      inst_id_q  <= NOP;
      pred_id_q  <= 1'b0;
      valid_id_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_id_q    <= pc_id_d;
      inst_id_q  <= inst_id_d;
      pred_id_q  <= pred_id_d;
      valid_id_q <= valid_id_d;
    end
  end

  assign bus.o_pc       = pc_q;
  assign bus.o_B        = is_br;
  assign bus.o_flush    = bus.i_PreWrong & ~bus.stall;
  assign bus.o_pc_id    = pc_id_q;
  assign bus.o_inst_id  = inst_id_q;
  assign bus.o_pred_id  = pred_id_q;
  assign bus.o_valid_id = valid_id_q;

`ifdef BPU_PERF_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Only unstalled cycles count: a stalled EX re-presents the same branch next cycle.
  always_comb begin
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (!bus.stall && bus.i_ex_is_br) begin
      if (br_cnt_q != 32'hFFFF_FFFF) br_cnt_d = br_cnt_q + 32'd1;
      if (bus.i_PreWrong && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus.o_br_cnt   = br_cnt_q;
  assign bus.o_miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed vector table, reset/perf sequences, then random vs. reference model.
module tb_fetch_pc_unit;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ADDI  = 32'h0010_8093;  // addi x1,x1,1
  localparam logic [31:0] BEQ16 = 32'h0000_0863;  // beq x0,x0,+16
  localparam logic [31:0] JALM8 = 32'hFF9F_F06F;  // jal x0,-8

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_pc_unit_if #(.ADDR_W(32)) bus ();

  fetch_pc_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  // reference model state
  logic [31:0] m_pc, m_pc_id, m_inst_id;
  logic        m_pred, m_valid;

  typedef struct {
    logic        stall;
    logic        pw;
    logic [31:0] rpc;
    logic [31:0] inst;
    logic        bp;
    logic [31:0] e_pc;
    logic [31:0] e_pc_id;
    logic [31:0] e_inst_id;
    logic        e_pred;
    logic        e_valid;
    logic        e_b;
    logic        e_flush;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic st, logic pw, logic [31:0] rpc, logic [31:0] inst, logic bp,
                              logic [31:0] e_pc, logic [31:0] e_pc_id, logic [31:0] e_inst_id,
                              logic e_pred, logic e_valid, logic e_b, logic e_flush);
    vec_t v;
    v.stall = st; v.pw = pw; v.rpc = rpc; v.inst = inst; v.bp = bp;
    v.e_pc = e_pc; v.e_pc_id = e_pc_id; v.e_inst_id = e_inst_id;
    v.e_pred = e_pred; v.e_valid = e_valid; v.e_b = e_b; v.e_flush = e_flush;
    return v;
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic st, input logic pw, input logic [31:0] rpc,
                       input logic [31:0] inst, input logic bp);
    bus.stall         = st;
    bus.i_PreWrong    = pw;
    bus.i_redirect_pc = rpc;
    bus.i_inst        = inst;
    bus.i_BrPre       = bp;
`ifdef BPU_PERF_EN
    bus.i_ex_is_br    = 1'b0;
`endif
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_pc"},       bus.o_pc, 32'h0);
    chk({tag, "_valid"},    32'(bus.o_valid_id), 32'h0);
    chk({tag, "_inst_id"},  bus.o_inst_id, NOP);
    chk({tag, "_pc_id"},    bus.o_pc_id, 32'h0);
    chk({tag, "_pred"},     32'(bus.o_pred_id), 32'h0);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_pc_id = 32'h0; m_inst_id = NOP; m_pred = 1'b0; m_valid = 1'b0;
  endtask

  // Next-state rules written straight from the priority list: stall, redirect, taken branch, jal, +4.
  task automatic model_step(input logic st, input logic pw, input logic [31:0] rpc,
                            input logic [31:0] inst, input logic bp);
    int off_b, off_j;
    off_b = int'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    off_j = int'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
    if (st) begin
      // everything holds
    end else if (pw) begin
      m_pc = rpc; m_inst_id = NOP; m_valid = 1'b0; m_pred = 1'b0;
    end else begin
      m_pc_id = m_pc; m_inst_id = inst; m_valid = 1'b1;
      if (inst[6:0] == 7'h63 && bp) begin
        m_pc = m_pc + 32'(off_b); m_pred = 1'b1;
      end else if (inst[6:0] == 7'h6F) begin
        m_pc = m_pc + 32'(off_j); m_pred = 1'b1;
      end else begin
        m_pc = m_pc + 32'd4; m_pred = 1'b0;
      end
    end
    exp_q.push_back(m_pc);
    exp_q.push_back(m_inst_id);
    exp_q.push_back({30'b0, m_valid, m_pred});
    exp_q.push_back(m_pc_id);
  endtask

  initial begin
    logic [31:0] r, inst, rpc;
    logic st, pw, bp, exp_vld;

    // vector table: each row is one cycle, registered expectations are after its rising edge
    tbl.push_back(mk(0,0,0,ADDI,0,          32'h04, 32'h00, ADDI, 0,1,0,0));
    tbl.push_back(mk(0,0,0,ADDI,1,          32'h08, 32'h04, ADDI, 0,1,0,0));
    tbl.push_back(mk(0,0,0,ADDI,0,          32'h0C, 32'h08, ADDI, 0,1,0,0));
    tbl.push_back(mk(0,1,32'h20,ADDI,0,     32'h20, 32'h0,  NOP,  0,0,0,1));
    tbl.push_back(mk(0,0,0,BEQ16,1,         32'h30, 32'h20, BEQ16,1,1,1,0));
    tbl.push_back(mk(0,1,32'h20,ADDI,0,     32'h20, 32'h0,  NOP,  0,0,0,1));
    tbl.push_back(mk(0,0,0,BEQ16,0,         32'h24, 32'h20, BEQ16,0,1,1,0));
    tbl.push_back(mk(0,1,32'h40,ADDI,0,     32'h40, 32'h0,  NOP,  0,0,0,1));
    tbl.push_back(mk(0,0,0,JALM8,1,         32'h38, 32'h40, JALM8,1,1,0,0));
    tbl.push_back(mk(0,1,32'h40,ADDI,0,     32'h40, 32'h0,  NOP,  0,0,0,1));
    tbl.push_back(mk(0,0,0,JALM8,0,         32'h38, 32'h40, JALM8,1,1,0,0));
    tbl.push_back(mk(1,1,32'h100,ADDI,0,    32'h38, 32'h40, JALM8,1,1,0,0));
    tbl.push_back(mk(1,1,32'h100,ADDI,0,    32'h38, 32'h40, JALM8,1,1,0,0));
    tbl.push_back(mk(0,1,32'h100,ADDI,0,    32'h100,32'h0,  NOP,  0,0,0,1));
    tbl.push_back(mk(0,0,0,ADDI,0,          32'h104,32'h100,ADDI, 0,1,0,0));
    tbl.push_back(mk(0,1,32'hFFFF_FFFC,ADDI,0, 32'hFFFF_FFFC,32'h0,NOP,0,0,0,1));
    tbl.push_back(mk(0,0,0,ADDI,0,          32'h0,  32'hFFFF_FFFC, ADDI, 0,1,0,0));
    tbl.push_back(mk(0,1,32'h20,ADDI,0,     32'h20, 32'h0,  NOP,  0,0,0,1));
    tbl.push_back(mk(1,0,0,BEQ16,1,         32'h20, 32'h0,  NOP,  0,0,1,0));
    tbl.push_back(mk(0,0,0,BEQ16,1,         32'h30, 32'h20, BEQ16,1,1,1,0));
    tbl.push_back(mk(0,1,32'h102,ADDI,0,    32'h102,32'h0,  NOP,  0,0,0,1));
    tbl.push_back(mk(0,0,0,ADDI,0,          32'h106,32'h102,ADDI, 0,1,0,0));

    // reset
    drive(0, 0, 32'h0, ADDI, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].stall, tbl[i].pw, tbl[i].rpc, tbl[i].inst, tbl[i].bp);
      #2;
      chk($sformatf("v%0d_B", i),     32'(bus.o_B),     32'(tbl[i].e_b));
      chk($sformatf("v%0d_flush", i), 32'(bus.o_flush), 32'(tbl[i].e_flush));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pc", i),      bus.o_pc,             tbl[i].e_pc);
      chk($sformatf("v%0d_valid", i),   32'(bus.o_valid_id),  32'(tbl[i].e_valid));
      chk($sformatf("v%0d_pred", i),    32'(bus.o_pred_id),   32'(tbl[i].e_pred));
      chk($sformatf("v%0d_inst_id", i), bus.o_inst_id,        tbl[i].e_inst_id);
      if (tbl[i].e_valid) chk($sformatf("v%0d_pc_id", i), bus.o_pc_id, tbl[i].e_pc_id);
    end

    // reset in the middle of traffic beats stall and redirect
    drive(1, 1, 32'h300, BEQ16, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_state("midrst");
    rst_n = 1'b1;

`ifdef BPU_PERF_EN
    drive(0, 1, 32'h200, ADDI, 0); bus.i_ex_is_br = 1'b1;   // counted miss
    @(posedge clk); #1;
    drive(1, 1, 32'h200, ADDI, 0); bus.i_ex_is_br = 1'b1;   // stalled, ignored
    @(posedge clk); #1;
    drive(0, 0, 32'h0, ADDI, 0);   bus.i_ex_is_br = 1'b1;   // counted, correct
    @(posedge clk); #1;
    drive(0, 0, 32'h0, ADDI, 0);
    chk("perf_br_cnt",   bus.o_br_cnt,   32'd2);
    chk("perf_miss_cnt", bus.o_miss_cnt, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("perf_rst_br", bus.o_br_cnt, 32'd0);
    rst_n = 1'b1;
`else
    drive(0, 0, 32'h0, ADDI, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
`endif

    // random traffic against the reference model
    model_reset();
    for (int c = 0; c < 400; c++) begin
      r  = $urandom;
      st = ($urandom_range(0, 4) == 0);
      pw = ($urandom_range(0, 7) == 0);
      bp = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0: inst = {r[31:7], 7'h63};
        1: inst = {r[31:7], 7'h6F};
        2: inst = ADDI;
        default: inst = r;
      endcase
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4) : $urandom;
      drive(st, pw, rpc, inst, bp);
      #2;
      chk("rnd_B",     32'(bus.o_B),     32'(inst[6:0] == 7'h63));
      chk("rnd_flush", 32'(bus.o_flush), 32'(pw & ~st));
      model_step(st, pw, rpc, inst, bp);
      @(posedge clk);
      #1;
      chk("rnd_pc",      bus.o_pc,      exp_q.pop_front());
      chk("rnd_inst_id", bus.o_inst_id, exp_q.pop_front());
      r = exp_q.pop_front();
      exp_vld = r[1];
      chk("rnd_vld_pred", {30'b0, bus.o_valid_id, bus.o_pred_id}, r);
      r = exp_q.pop_front();
      if (exp_vld) chk("rnd_pc_id", bus.o_pc_id, r);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
